// File: rtl/sfx_pkg.sv
// Shared types, constants and the note table for the sound-effect scheduler.
package sfx_pkg;

  localparam int unsigned HP_W      = 21;
  localparam int unsigned DUR_W     = 16;
  localparam int unsigned SAMPLE_W  = 24;
  localparam int unsigned SFX_COUNT = 4;
  localparam int unsigned SFX_NOTES = 2;

  localparam int unsigned SFX_JUMP  = 0;
  localparam int unsigned SFX_HIT   = 1;
  localparam int unsigned SFX_SCORE = 2;
  localparam int unsigned SFX_OVER  = 3;

  // One note: half-period in clk cycles and duration in ticks.
  typedef struct packed {
    logic [HP_W-1:0]  hp;
    logic [DUR_W-1:0] dur;
  } note_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Indexed [effect][note]; half-periods assume a 50 MHz clk.
  localparam note_t SFX_TABLE [SFX_COUNT][SFX_NOTES] = '{
    '{'{hp: 21'd113636, dur: 16'd80},  '{hp: 21'd56818,  dur: 16'd80}},
    '{'{hp: 21'd227272, dur: 16'd40},  '{hp: 21'd303030, dur: 16'd60}},
    '{'{hp: 21'd75843,  dur: 16'd60},  '{hp: 21'd50619,  dur: 16'd120}},
    '{'{hp: 21'd303030, dur: 16'd120}, '{hp: 21'd454545, dur: 16'd160}}
  };

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: phase counter with loadable half-period and polarity output.
module sfx_tone_gen
  import sfx_pkg::*;
#(
  parameter int unsigned AMPLITUDE = 200000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [HP_W-1:0]            half_period,
  output logic signed [SAMPLE_W-1:0] tone_c
);

  localparam logic signed [SAMPLE_W-1:0] AMP_POS = SAMPLE_W'(AMPLITUDE);
  localparam logic signed [SAMPLE_W-1:0] AMP_NEG = -AMP_POS;

  logic [HP_W-1:0] hp_q;
  logic [HP_W-1:0] phase;
  logic            polarity;

  // Half-period latch (zero treated as one), phase count and polarity toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_q     <= HP_W'(1);
      phase    <= '0;
      polarity <= 1'b0;
    end else begin
      if (load) begin
        hp_q <= (half_period == '0) ? HP_W'(1) : half_period;
      end
      if (clear) begin
        phase    <= '0;
        polarity <= 1'b0;
      end else if (enable) begin
        if (phase == hp_q - HP_W'(1)) begin
          phase    <= '0;
          polarity <= ~polarity;
        end else begin
          phase <= phase + HP_W'(1);
        end
      end
    end
  end

  assign tone_c = polarity ? AMP_NEG : AMP_POS;

endmodule

// File: rtl/sfx_tone_scheduler.sv
// Prioritised sound-effect scheduler streaming square-wave samples to the codec.
// Optional build macro SFX_PREEMPT_EN: a higher-priority pending request aborts
// the playing effect at the next tick boundary.
module sfx_tone_scheduler
  import sfx_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned NOTES_PER_SFX = 2,
  parameter int unsigned TICK_DIV      = 50000,
  parameter int unsigned HP_SHIFT      = 0,
  parameter int unsigned AMPLITUDE     = 200000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       write_ready,
  output logic                       write,
  output logic signed [23:0]         sample,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       done
);

  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned NOTE_W = (NOTES_PER_SFX > 1) ? $clog2(NOTES_PER_SFX) : 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t state;
  state_t next_state;

  logic [NUM_REQ-1:0]         pending;
  logic [NUM_REQ-1:0]         clr_mask;
  logic [ID_W-1:0]            win_idx;
  logic                       win_valid;
  logic [NOTE_W-1:0]          note_idx;
  logic [DUR_W-1:0]           dur;
  logic [TICK_W-1:0]          tick_cnt;
  logic                       tick_c;
  logic                       last_note_c;
  logic                       preempt_c;
  logic                       grant_c;
  note_t                      cur_note_c;
  logic [HP_W-1:0]            hp_shifted_c;
  logic signed [SAMPLE_W-1:0] tone_c;
  logic                       busy_d;
  logic                       done_d;
  logic signed [SAMPLE_W-1:0] sample_d;

  // Fixed-priority arbiter: lowest set pending index wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_valid = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
  end

  assign tick_c       = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign last_note_c  = (note_idx == NOTE_W'(NOTES_PER_SFX - 1));
  assign cur_note_c   = SFX_TABLE[grant_id][note_idx];
  assign hp_shifted_c = cur_note_c.hp >> HP_SHIFT;

`ifdef SFX_PREEMPT_EN
  assign preempt_c = win_valid && (win_idx < grant_id) && tick_c &&
                     ((state == PLAY) || (state == GAP));
`else
  assign preempt_c = 1'b0;
`endif

  assign grant_c  = ((state == IDLE) && win_valid) || preempt_c;
  assign clr_mask = grant_c ? (NUM_REQ'(1) << win_idx) : '0;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (win_valid) next_state = LOAD;
      end
      LOAD: begin
        if (cur_note_c.dur == '0) next_state = last_note_c ? DONE : GAP;
        else                      next_state = PLAY;
      end
      PLAY: begin
        if (preempt_c)                         next_state = LOAD;
        else if (tick_c && (dur == DUR_W'(1))) next_state = last_note_c ? DONE : GAP;
      end
      GAP: begin
        if (preempt_c || tick_c) next_state = LOAD;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode, registered below so busy/done track the state being entered.
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    sample_d = '0;
    busy_d   = (next_state == LOAD) || (next_state == PLAY) || (next_state == GAP);
    done_d   = (next_state == DONE);
    if (state == PLAY) sample_d = tone_c;
  end

  // Output registers; the sample only advances on an accepted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      write  <= 1'b0;
      sample <= '0;
    end else begin
      busy  <= busy_d;
      done  <= done_d;
      write <= 1'b1;
      if (write && write_ready) sample <= sample_d;
    end
  end

  // Pending requests, grant, note index, duration and tick prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      grant_id <= '0;
      note_idx <= '0;
      dur      <= '0;
      tick_cnt <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | req;
      if (grant_c) begin
        grant_id <= win_idx;
        note_idx <= '0;
      end else if ((state == GAP) && tick_c) begin
        note_idx <= note_idx + NOTE_W'(1);
      end
      if (state == LOAD) begin
        dur <= cur_note_c.dur;
      end else if ((state == PLAY) && tick_c) begin
        dur <= dur - DUR_W'(1);
      end
      if (((state == PLAY) || (state == GAP)) && !tick_c) begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end else begin
        tick_cnt <= '0;
      end
    end
  end

  sfx_tone_gen #(
    .AMPLITUDE (AMPLITUDE)
  ) u_tone_gen (
    .clk         (clk),
    .reset       (reset),
    .load        (state == LOAD),
    .clear       (state != PLAY),
    .enable      (state == PLAY),
    .half_period (hp_shifted_c),
    .tone_c      (tone_c)
  );

endmodule

// File: tb/tb_sfx_tone_scheduler.sv
// Directed self-checking bench for sfx_tone_scheduler (TICK_DIV=4, HP_SHIFT=14).
module tb_sfx_tone_scheduler;

  localparam int unsigned TICK_DIV = 4;
  localparam logic [23:0] AMP_P = 24'd200000;
  localparam logic [23:0] AMP_N = 24'hFCF2C0;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [3:0]         req = '0;
  logic               write_ready = 1'b1;
  logic               write;
  logic signed [23:0] sample;
  logic               busy;
  logic [1:0]         grant_id;
  logic               done;
  logic [23:0]        sample_u;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int base;

  assign sample_u = sample;

  sfx_tone_scheduler #(
    .NUM_REQ       (4),
    .NOTES_PER_SFX (2),
    .TICK_DIV      (TICK_DIV),
    .HP_SHIFT      (14),
    .AMPLITUDE     (200000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .write_ready (write_ready),
    .write       (write),
    .sample      (sample),
    .busy        (busy),
    .grant_id    (grant_id),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Count done pulses.
  always @(negedge clk) begin
    if (!reset && done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    @(negedge clk);
    req = v;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n;
    n = 0;
    while (!done && n < max) begin
      tick(1);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  // Effect 0 timeline relative to the request edge E0; optional write stall.
  task automatic run_jump(input bit stall, input string p);
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk); #1;
    req = '0;
    check({p, "_busy_e0"}, 32'(busy), 32'd0);
    tick(1);
    check({p, "_busy_e1"}, 32'(busy), 32'd1);
    check({p, "_grant_e1"}, 32'(grant_id), 32'd0);
    tick(1);
    check({p, "_sample_e2"}, 32'(sample_u), 32'd0);
    tick(1);
    check({p, "_sample_e3"}, 32'(sample_u), 32'(AMP_P));
    if (!stall) begin
      tick(5);
      check({p, "_sample_e8"}, 32'(sample_u), 32'(AMP_P));
      tick(1);
      check({p, "_sample_e9"}, 32'(sample_u), 32'(AMP_N));
      tick(313);
    end else begin
      tick(16);
      check({p, "_sample_e19"}, 32'(sample_u), 32'(AMP_P));
      write_ready = 1'b0;
      tick(6);
      check({p, "_hold_e25"}, 32'(sample_u), 32'(AMP_P));
      check({p, "_write_stall"}, 32'(write), 32'd1);
      tick(94);
      check({p, "_hold_e119"}, 32'(sample_u), 32'(AMP_P));
      write_ready = 1'b1;
      tick(2);
      check({p, "_sample_e121"}, 32'(sample_u), 32'(AMP_N));
      tick(201);
    end
    check({p, "_note0_last"}, 32'(sample_u), 32'(AMP_N));
    tick(1);
    check({p, "_gap_silent"}, 32'(sample_u), 32'd0);
    tick(5);
    check({p, "_note1_first"}, 32'(sample_u), 32'(AMP_P));
    tick(3);
    check({p, "_note1_toggle"}, 32'(sample_u), 32'(AMP_N));
    tick(315);
    check({p, "_busy_e646"}, 32'(busy), 32'd1);
    check({p, "_done_e646"}, 32'(done), 32'd0);
    tick(1);
    check({p, "_busy_e647"}, 32'(busy), 32'd0);
    check({p, "_done_e647"}, 32'(done), 32'd1);
    check({p, "_sample_e647"}, 32'(sample_u), 32'(AMP_P));
    tick(1);
    check({p, "_done_e648"}, 32'(done), 32'd0);
    check({p, "_sample_e648"}, 32'(sample_u), 32'd0);
  endtask

  initial begin
    int n;
    // Reset values.
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_sample", 32'(sample_u), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    check("write_after_rst", 32'(write), 32'd1);

    // Single request on an idle scheduler.
    run_jump(1'b0, "jump");
    tick(5);

    // Simultaneous requests: 1 before 3.
    base = done_cnt;
    pulse(4'b1010);
    tick(2);
    check("simul_first_grant", 32'(grant_id), 32'd1);
    wait_done(3000, "simul_1");
    check("simul_done_id1", 32'(grant_id), 32'd1);
    tick(2);
    check("simul_second_grant", 32'(grant_id), 32'd3);
    check("simul_second_busy", 32'(busy), 32'd1);
    wait_done(3000, "simul_3");
    check("simul_done_id3", 32'(grant_id), 32'd3);
    tick(5);
    check("simul_idle", 32'(busy), 32'd0);
    check("simul_done_count", 32'(done_cnt - base), 32'd2);

    // Re-request during play: three extra pulses give one replay.
    base = done_cnt;
    pulse(4'b0100);
    tick(10);
    pulse(4'b0100);
    tick(3);
    pulse(4'b0100);
    pulse(4'b0100);
    wait_done(3000, "rereq_1");
    tick(2);
    check("rereq_replay_busy", 32'(busy), 32'd1);
    check("rereq_replay_grant", 32'(grant_id), 32'd2);
    wait_done(3000, "rereq_2");
    tick(5);
    check("rereq_idle", 32'(busy), 32'd0);
    check("rereq_done_count", 32'(done_cnt - base), 32'd2);

    // Request held across its own grant cycle is kept.
    base = done_cnt;
    @(negedge clk);
    req = 4'b0100;
    tick(2);
    req = '0;
    wait_done(3000, "hold_1");
    tick(2);
    check("hold_replay_busy", 32'(busy), 32'd1);
    wait_done(3000, "hold_2");
    tick(5);
    check("hold_done_count", 32'(done_cnt - base), 32'd2);

    // Backpressure keeps the sample but not the tone timing.
    run_jump(1'b1, "stall");
    tick(5);

    // Async reset mid-play clears everything including pending.
    pulse(4'b0001);
    pulse(4'b0010);
    tick(20);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_write", 32'(write), 32'd0);
    check("arst_sample", 32'(sample_u), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(20);
    check("arst_pending_clear", 32'(busy), 32'd0);
    check("arst_write_back", 32'(write), 32'd1);

    // Higher-priority request while effect 3 plays.
    pulse(4'b1000);
    tick(20);
    base = done_cnt;
    pulse(4'b0001);
`ifdef SFX_PREEMPT_EN
    n = 0;
    while (grant_id != 2'd0 && n < int'(TICK_DIV) + 2) begin
      tick(1);
      n++;
    end
    check("preempt_grant", 32'(grant_id), 32'd0);
    check("preempt_no_done", 32'(done_cnt - base), 32'd0);
    check("preempt_busy", 32'(busy), 32'd1);
    wait_done(3000, "preempt_0");
    check("preempt_done_id", 32'(grant_id), 32'd0);
    tick(2);
    check("preempt_done_count", 32'(done_cnt - base), 32'd1);
`else
    n = int'(TICK_DIV) + 2;
    tick(n);
    check("nopreempt_grant", 32'(grant_id), 32'd3);
    wait_done(3000, "nopreempt_3");
    check("nopreempt_done_id", 32'(grant_id), 32'd3);
    tick(2);
    check("nopreempt_next_grant", 32'(grant_id), 32'd0);
    wait_done(3000, "nopreempt_0");
    tick(2);
    check("nopreempt_done_count", 32'(done_cnt - base), 32'd2);
`endif
    tick(5);
    check("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
